// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer slice.
// Optional auto-repeat is selected with the DEBOUNCE_REPEAT_EN macro.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_e;

    localparam int unsigned NUM_BTN_DEF        = 5;
    localparam int unsigned STABLE_SAMPLES_DEF = 3;
    localparam int unsigned REPEAT_DELAY_DEF   = 25;
    localparam int unsigned REPEAT_PERIOD_DEF  = 5;

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw inputs and tick in, debounced events out.
// Optional auto-repeat (DEBOUNCE_REPEAT_EN) does not change this bundle.
interface button_debouncer_if
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN = NUM_BTN_DEF
);
    logic               tick_src;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               sample_tick;

    modport slave (
        input  tick_src, btn_raw,
        output btn_level, btn_press, btn_release, sample_tick
    );

    modport master (
        output tick_src, btn_raw,
        input  btn_level, btn_press, btn_release, sample_tick
    );
endinterface

// File: rtl/btn_debounce_cell.sv
// One debounced button channel: 2-flop synchronizer, 4-state FSM, registered events.
// DEBOUNCE_REPEAT_EN adds held-button auto-repeat press pulses.
module btn_debounce_cell
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF,
    parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    localparam int unsigned CNT_W = cnt_width(STABLE_SAMPLES);

    logic [1:0]       sync_q;
    logic             sync;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_d, press_d, release_d;
    logic             rep_fire;

    // Synchronizer for the asynchronous button level
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], btn_raw};
    end
    assign sync    = sync_q[1];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_en) begin
            case (state_q)
                RELEASED: begin
                    if (sync) begin
                        state_d = PRESS_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!sync) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(STABLE_SAMPLES)) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state_d = RELEASE_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASE_PEND: begin
                    if (sync) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(STABLE_SAMPLES)) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned REP_W = cnt_width(REPEAT_DELAY);

    logic [REP_W-1:0] rep_q, rep_d;

    always_ff @(posedge clk) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end

    // Repeat counter runs only while held; reload shortens later repeat gaps
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (state_q == PRESS_PEND && state_d == HELD) begin
            rep_d = '0;
        end else if (state_d == RELEASED) begin
            rep_d = '0;
        end else if (sample_en && state_q == HELD && sync) begin
            if (rep_q + REP_W'(1) == REP_W'(REPEAT_DELAY)) begin
                rep_fire = 1'b1;
                rep_d    = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rep_d    = rep_q + REP_W'(1);
            end
        end
    end
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rep_fire       = 1'b0;
`endif

    always_comb begin
        press_d   = (state_q == PRESS_PEND   && state_d == HELD) || rep_fire;
        release_d = (state_q == RELEASE_PEND && state_d == RELEASED);
        level_d   = btn_level;
        if (state_q == PRESS_PEND && state_d == HELD) level_d = 1'b1;
        if (release_d)                                level_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Top: turns the divided square wave into a sample strobe and fans out per-button cells.
// Auto-repeat is compiled in when DEBOUNCE_REPEAT_EN is defined.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN        = NUM_BTN_DEF,
    parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF,
    parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    button_debouncer_if.slave   bus
);
    logic               tick_q;
    logic               sample_en;
    logic               sample_tick_q;
    logic [NUM_BTN-1:0] raw, level, press, rel;

    // tick_q tracks tick_src even in reset so reset release cannot fake an edge
    always_ff @(posedge clk) begin
        tick_q <= bus.tick_src;
    end
    assign sample_en = bus.tick_src & ~tick_q;

    always_ff @(posedge clk) begin
        if (rst) sample_tick_q <= 1'b0;
        else     sample_tick_q <= sample_en;
    end

    assign raw             = bus.btn_raw;
    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.sample_tick = sample_tick_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_cell #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .sample_en   (sample_en),
            .btn_raw     (raw[i]),
            .btn_level   (level[i]),
            .btn_press   (press[i]),
            .btn_release (rel[i])
        );
    end

endmodule
